// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//
// Builds 32-bit instruction words from their separate fields and streams them,
// each with its word address, to the instruction-memory loader. It is the
// encode-side counterpart of the instruction-register field decoder.
//
// A job is started with a base address and a word count. Field sets arrive on
// a valid/ready stream and are packed by format, selected by op[5:4]:
//   00 = R {op,rs,rt,rd,sa,func}
//   01 = I {op,rs,rt,immediate}
//   10 = J {op,address}
//   11 = illegal: the set is consumed, dropped and counted in err_cnt
// Packed words go through a 2-entry FIFO whose head is presented on out_*.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin a job, sampled only while idle
//   cfg_base, cfg_len     first word address and word count, latched on start
//   in_valid / in_ready   field-set handshake
//   op,rs,rt,rd,sa,func,
//   immediate, address    instruction fields
//   out_valid / out_ready output word handshake
//   out_data, out_addr    head word and its address (cfg_base + words emitted)
//   busy                  a job is in progress (not idle)
//   done                  one-cycle pulse when the job completes
//   err_cnt               saturating count of dropped illegal-format sets
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int AW    = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    cfg_base,
    input  logic [AW-1:0]    cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic [4:0]       sa,
    input  logic [5:0]       func,
    input  logic [15:0]      immediate,
    input  logic [25:0]      address,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [AW-1:0]    out_addr,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0]    AW_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t state;
    state_t state_next;

    logic [AW-1:0]    base_q;
    logic [AW-1:0]    len_q;
    logic [AW-1:0]    acc_cnt;
    logic [AW-1:0]    emit_cnt;
    logic [AW-1:0]    emit_next;
    logic [ERR_W-1:0] err_q;

    logic [31:0]      fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;
    logic [31:0]      last_word;

    logic [31:0]      packed_word;
    logic             illegal;
    logic             in_fire;
    logic             push;
    logic             pop;
    logic             job_start;

    // Format packing; the illegal format produces no word.
    always_comb begin
        packed_word = '0;
        illegal     = 1'b0;
        case (op[5:4])
            2'b00:   packed_word = {op, rs, rt, rd, sa, func};
            2'b01:   packed_word = {op, rs, rt, immediate};
            2'b10:   packed_word = {op, address};
            default: illegal     = 1'b1;
        endcase
    end

    assign job_start = (state == IDLE) && start;
    assign in_fire   = in_valid && in_ready;
    assign push      = in_fire && !illegal;
    assign pop       = out_valid && out_ready;

    // Words emitted including a pop in this cycle, so the job ends in the
    // same cycle the last word leaves (or right away for a zero-length job).
    assign emit_next = emit_cnt + {{(AW-1){1'b0}}, pop};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (emit_next == len_q) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic. The full test looks at the current occupancy only, so a
    // pop in the same cycle does not open a slot until the next cycle.
    always_comb begin
        in_ready  = (state == RUN) && (fifo_cnt < 2'd2) && (acc_cnt < len_q);
        out_valid = (fifo_cnt != 2'd0);
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    // Job configuration and progress counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            len_q    <= '0;
            acc_cnt  <= '0;
            emit_cnt <= '0;
        end else if (job_start) begin
            base_q   <= cfg_base;
            len_q    <= cfg_len;
            acc_cnt  <= '0;
            emit_cnt <= '0;
        end else begin
            if (push) acc_cnt  <= acc_cnt + AW_ONE;
            if (pop)  emit_cnt <= emit_cnt + AW_ONE;
        end
    end

    // Illegal-format counter survives across jobs and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (in_fire && illegal && (err_q != ERR_MAX)) begin
            err_q <= err_q + ERR_ONE;
        end
    end

    // FIFO storage needs no reset: it is only read while occupied.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= packed_word;
    end

    // FIFO pointers and occupancy. last_word keeps the most recently presented
    // head so out_data holds its value once the FIFO runs empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
            last_word <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                last_word <= fifo_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign out_data = out_valid ? fifo_mem[rd_ptr] : last_word;
    assign out_addr = base_q + emit_cnt;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder. Stimulus pushes the hand-computed word and
// address of every legal field set into a scoreboard queue as it is accepted;
// a monitor process forked from the same initial block pops and compares each
// word the DUT hands over on out_valid && out_ready.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge or 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_base;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  func;
    logic [15:0] immediate;
    logic [25:0] address;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_addr;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  addr;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] next_addr;
    int         n_checks = 0;
    int         n_fail   = 0;

    // Hand-packed words.
    localparam logic [31:0] W_R1 = 32'h3EB43C00;
    localparam logic [31:0] W_I1 = 32'h57E0E38F;
    localparam logic [31:0] W_J1 = 32'h82D5D355;
    localparam logic [31:0] W_R2 = 32'h00221905;
    localparam logic [31:0] W_I2 = 32'h68641234;
    localparam logic [31:0] W_J2 = 32'hB0000ABC;

    instr_encoder #(.AW(8), .ERR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .sa        (sa),
        .func      (func),
        .immediate (immediate),
        .address   (address),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic runMonitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_word", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_out_data", out_data, e.data);
                    checkOutput("sb_out_addr", 32'(out_addr), 32'(e.addr));
                end
            end
        end
    endtask

    task automatic startJob(input logic [7:0] base, input logic [7:0] len);
        start    = 1'b1;
        cfg_base = base;
        cfg_len  = len;
        @(posedge clk); #1;
        start     = 1'b0;
        next_addr = base;
    endtask

    task automatic applyStimulus(input logic [5:0] o, input logic [4:0] f_rs,
                                 input logic [4:0] f_rt, input logic [4:0] f_rd,
                                 input logic [4:0] f_sa, input logic [5:0] f_func,
                                 input logic [15:0] f_imm, input logic [25:0] f_addr,
                                 input logic [31:0] exp_data, input logic legal);
        logic accepted;
        op        = o;
        rs        = f_rs;
        rt        = f_rt;
        rd        = f_rd;
        sa        = f_sa;
        func      = f_func;
        immediate = f_imm;
        address   = f_addr;
        in_valid  = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                if (legal) begin
                    sb_q.push_back('{data: exp_data, addr: next_addr});
                    next_addr = next_addr + 8'd1;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("accept_in_time", 32'(accepted), 32'd1);
    endtask

    task automatic waitDone(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checkOutput({tag, "_done_pulse"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        checkOutput({tag, "_done_clear"}, 32'(done), 32'd0);
        checkOutput({tag, "_busy_clear"}, 32'(busy), 32'd0);
        checkOutput({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"},  32'(in_ready),  32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_busy"},      32'(busy),      32'd0);
        checkOutput({tag, "_done"},      32'(done),      32'd0);
        checkOutput({tag, "_out_data"},  out_data,       32'd0);
        checkOutput({tag, "_out_addr"},  32'(out_addr),  32'd0);
        checkOutput({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_base  = '0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        op        = '0;
        rs        = '0;
        rt        = '0;
        rd        = '0;
        sa        = '0;
        func      = '0;
        immediate = '0;
        address   = '0;
        out_ready = 1'b1;
        next_addr = '0;

        fork
            runMonitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] test 1: R-format single word");
        startJob(8'h10, 8'd1);
        applyStimulus(6'h0F, 5'd21, 5'd20, 5'd7, 5'd16, 6'd0, 16'hFFFF, 26'h3FFFFFF, W_R1, 1'b1);
        checkOutput("t1_latency_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_out_data", out_data, W_R1);
        checkOutput("t1_out_addr", 32'(out_addr), 32'h10);
        checkOutput("t1_no_early_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        checkOutput("t1_done_after_pop", 32'(done), 32'd1);
        checkOutput("t1_hold_data", out_data, W_R1);
        @(posedge clk); #1;
        checkOutput("t1_done_one_cycle", 32'(done), 32'd0);
        checkOutput("t1_idle", 32'(busy), 32'd0);

        $display("[TB] test 2: I and J formats");
        startJob(8'h40, 8'd2);
        applyStimulus(6'h15, 5'd31, 5'd0, 5'd9, 5'd9, 6'h3F, 16'hE38F, 26'h1555555, W_I1, 1'b1);
        applyStimulus(6'h20, 5'd3, 5'd3, 5'd3, 5'd3, 6'h11, 16'h1234, 26'h2D5D355, W_J1, 1'b1);
        waitDone("t2");

        $display("[TB] test 3: backpressure");
        out_ready = 1'b0;
        startJob(8'h80, 8'd3);
        applyStimulus(6'h00, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'hAAAA, 26'h0, W_R2, 1'b1);
        applyStimulus(6'h1A, 5'd3, 5'd4, 5'd31, 5'd31, 6'h2A, 16'h1234, 26'h0, W_I2, 1'b1);
        op       = 6'h2C;
        address  = 26'h0000ABC;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t3_full_in_ready", 32'(in_ready), 32'd0);
            checkOutput("t3_head_data", out_data, W_R2);
            checkOutput("t3_head_addr", 32'(out_addr), 32'h80);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        applyStimulus(6'h2C, 5'd7, 5'd7, 5'd7, 5'd7, 6'h07, 16'h7777, 26'h0000ABC, W_J2, 1'b1);
        waitDone("t3");

        $display("[TB] test 4: illegal format");
        startJob(8'h50, 8'd2);
        applyStimulus(6'h0F, 5'd21, 5'd20, 5'd7, 5'd16, 6'd0, 16'h0, 26'h0, W_R1, 1'b1);
        applyStimulus(6'h30, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'h1, 32'd0, 1'b0);
        checkOutput("t4_err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("t4_still_busy", 32'(busy), 32'd1);
        applyStimulus(6'h20, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h2D5D355, W_J1, 1'b1);
        waitDone("t4");
        checkOutput("t4_err_kept", 32'(err_cnt), 32'd1);

        $display("[TB] test 5: address wrap and zero length");
        startJob(8'hFF, 8'd2);
        applyStimulus(6'h15, 5'd31, 5'd0, 5'd0, 5'd0, 6'd0, 16'hE38F, 26'h0, W_I1, 1'b1);
        applyStimulus(6'h0F, 5'd21, 5'd20, 5'd7, 5'd16, 6'd0, 16'h0, 26'h0, W_R1, 1'b1);
        waitDone("t5a");
        op       = 6'h0F;
        in_valid = 1'b1;
        startJob(8'h77, 8'd0);
        checkOutput("t5b_busy_c1", 32'(busy), 32'd1);
        checkOutput("t5b_done_c1", 32'(done), 32'd0);
        checkOutput("t5b_in_ready_c1", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("t5b_busy_c2", 32'(busy), 32'd1);
        checkOutput("t5b_done_c2", 32'(done), 32'd1);
        checkOutput("t5b_in_ready_c2", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("t5b_busy_c3", 32'(busy), 32'd0);
        checkOutput("t5b_done_c3", 32'(done), 32'd0);
        checkOutput("t5b_no_word", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        $display("[TB] test 6: reset mid-job");
        out_ready = 1'b0;
        startJob(8'h20, 8'd4);
        applyStimulus(6'h00, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h0, 26'h0, W_R2, 1'b1);
        applyStimulus(6'h1A, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h1234, 26'h0, W_I2, 1'b1);
        checkOutput("t6_queued", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("t6_async");
        sb_q.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("t6_fifo_empty", 32'(out_valid), 32'd0);
        startJob(8'h30, 8'd1);
        applyStimulus(6'h20, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000ABC, 32'h80000ABC, 1'b1);
        waitDone("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
